// File: rtl/sram_controller_if.sv
// Decoder read stream and loader write stream between the frame pipeline and the SRAM controller.
// master = decoder/loader side, slave = controller side.
interface sram_controller_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic                  load_mode;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  busy;

  modport master (
    output load_mode, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_data, rd_valid, wr_ready, busy
  );

  modport slave (
    input  load_mode, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_data, rd_valid, wr_ready, busy
  );
endinterface

// File: rtl/sram_controller.sv
// Async SRAM port owner: 2-cycle address-to-data reads for the decoder, 4-cycle writes for the loader.
// Writes are valid/ready; wr_ready drops for the whole write sequence, which also stalls reads.
module sram_controller #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sram_controller_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_WIDTH-1:0] io_SRAM_DQ,
  output logic                  o_SRAM_WE_N,
  output logic                  o_SRAM_CE_N,
  output logic                  o_SRAM_OE_N,
  output logic                  o_SRAM_LB_N,
  output logic                  o_SRAM_UB_N
);

  typedef enum logic [1:0] {
    ST_RD       = 2'd0,
    ST_WR_SETUP = 2'd1,
    ST_WR_PULSE = 2'd2,
    ST_WR_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  we_n_q, we_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  ctrl_n_q;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_ready_q, wr_ready_d;
  logic                  busy_q, busy_d;

  // State register plus every registered output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RD;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ctrl_n_q   <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ctrl_n_q   <= 1'b0;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= io_SRAM_DQ;
      end
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RD:       if (wr_ready_q && bus.wr_valid) state_nxt = ST_WR_SETUP;
      ST_WR_SETUP: state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  state_nxt = ST_RD;
      default:     state_nxt = ST_RD;
    endcase
  end

  // Pin values are decided from the state being entered so they land on the same edge.
  always_comb begin
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    case (state_nxt)
      ST_RD: begin
        addr_d = bus.rd_addr;
        oe_n_d = 1'b0;
      end
      ST_WR_SETUP: begin
        addr_d   = bus.wr_addr;
        dq_out_d = bus.wr_data;
        dq_oe_d  = 1'b1;
      end
      ST_WR_PULSE: begin
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end
      ST_WR_HOLD: begin
        dq_oe_d = 1'b1;
      end
      default: begin
        dq_oe_d = 1'b0;
      end
    endcase
    rd_pend_d  = (state_nxt == ST_RD);
    wr_ready_d = (state_nxt == ST_RD) && bus.load_mode;
    busy_d     = (state_nxt != ST_RD);
  end

  assign io_SRAM_DQ   = dq_oe_q ? dq_out_q : {DATA_WIDTH{1'bz}};
  assign o_SRAM_ADDR  = addr_q;
  assign o_SRAM_WE_N  = we_n_q;
  assign o_SRAM_OE_N  = oe_n_q;
  assign o_SRAM_CE_N  = ctrl_n_q;
  assign o_SRAM_LB_N  = ctrl_n_q;
  assign o_SRAM_UB_N  = ctrl_n_q;

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM whose unwritten words read as addr^0xA5A5.
module tb_sram_controller;
  localparam int AW = 20;
  localparam int DW = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];

  always #5 i_clk = ~i_clk;

  sram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (sram_we_n),
    .o_SRAM_CE_N (sram_ce_n),
    .o_SRAM_OE_N (sram_oe_n),
    .o_SRAM_LB_N (sram_lb_n),
    .o_SRAM_UB_N (sram_ub_n)
  );

  assign sram_dq = (!sram_oe_n && sram_we_n) ?
                   (written[sram_addr] ? mem[sram_addr] : (sram_addr[15:0] ^ 16'hA5A5)) : 'z;

  always @(posedge i_clk) begin
    if (!sram_we_n && !sram_ce_n) begin
      mem[sram_addr]     <= sram_dq;
      written[sram_addr] <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; bus.load_mode = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    tick; tick;
    checks++;
    if ({sram_we_n, sram_oe_n, bus.rd_valid, bus.wr_ready, bus.busy} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl: we_n/oe_n/vld/rdy/busy got %b expected 11000",
                         {sram_we_n, sram_oe_n, bus.rd_valid, bus.wr_ready, bus.busy});
    end
    checks++;
    if (sram_addr !== 20'h0 || bus.rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_regs: addr %h data %h expected 0 0", sram_addr, bus.rd_data);
    end
    // Start a write, then reset while WE_N is low.
    i_rst = 1'b0; bus.load_mode = 1'b1; bus.wr_addr = 20'h00500; bus.wr_data = 16'h1234;
    tick;
    checks++;
    if (bus.wr_ready !== 1'b1 || {sram_ce_n, sram_lb_n, sram_ub_n} !== 3'b000) begin
      errors++; $display("FAIL reset_release: rdy %b ce/lb/ub %b expected 1 000",
                         bus.wr_ready, {sram_ce_n, sram_lb_n, sram_ub_n});
    end
    bus.wr_valid = 1'b1;
    tick;
    bus.wr_valid = 1'b0;
    tick;
    checks++;
    if (sram_we_n !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_pulse_entry: we_n %b busy %b expected 0 1", sram_we_n, bus.busy);
    end
    i_rst = 1'b1;
    tick;
    checks++;
    if ({sram_we_n, sram_oe_n, bus.busy, bus.rd_valid, bus.wr_ready} !== 5'b11000) begin
      errors++; $display("FAIL reset_abort: we_n/oe_n/busy/vld/rdy got %b expected 11000",
                         {sram_we_n, sram_oe_n, bus.busy, bus.rd_valid, bus.wr_ready});
    end
    tick; tick;
    i_rst = 1'b0; bus.load_mode = 1'b0;
    tick;
    checks++;
    if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_to_rd: oe_n %b we_n %b busy %b expected 0 1 0",
                         sram_oe_n, sram_we_n, bus.busy);
    end
  endtask

  task automatic test_read_latency;
    bus.load_mode = 1'b0;
    bus.rd_addr = 20'h00010;
    tick;
    checks++;
    if (sram_addr !== 20'h00010 || sram_oe_n !== 1'b0) begin
      errors++; $display("FAIL rd_addr_pins: addr %h oe_n %b expected 00010 0", sram_addr, sram_oe_n);
    end
    bus.rd_addr = 20'h00011;
    tick;
    checks++;
    if (bus.rd_data !== 16'hA5B5 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL rd_lat0: data %h vld %b expected a5b5 1", bus.rd_data, bus.rd_valid);
    end
    bus.rd_addr = 20'h00012;
    tick;
    checks++;
    if (bus.rd_data !== 16'hA5B4 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL rd_lat1: data %h vld %b expected a5b4 1", bus.rd_data, bus.rd_valid);
    end
    tick;
    checks++;
    if (bus.rd_data !== 16'hA5B7 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL rd_lat2: data %h vld %b expected a5b7 1", bus.rd_data, bus.rd_valid);
    end
  endtask

  task automatic test_single_write;
    bus.load_mode = 1'b1;
    tick;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready_up: got %b expected 1", bus.wr_ready);
    end
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h12345; bus.wr_data = 16'hBEEF;
    tick;
    bus.wr_valid = 1'b0;
    checks++;
    if ({sram_we_n, sram_oe_n, bus.wr_ready, bus.busy} !== 4'b1101 ||
        sram_addr !== 20'h12345 || sram_dq !== 16'hBEEF) begin
      errors++; $display("FAIL wr_setup: we/oe/rdy/busy %b addr %h dq %h expected 1101 12345 beef",
                         {sram_we_n, sram_oe_n, bus.wr_ready, bus.busy}, sram_addr, sram_dq);
    end
    tick;
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 20'h12345 || sram_dq !== 16'hBEEF) begin
      errors++; $display("FAIL wr_pulse: we_n %b addr %h dq %h expected 0 12345 beef",
                         sram_we_n, sram_addr, sram_dq);
    end
    tick;
    checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== 20'h12345 ||
        sram_dq !== 16'hBEEF || bus.busy !== 1'b1) begin
      errors++; $display("FAIL wr_hold: we_n %b oe_n %b addr %h dq %h busy %b expected 1 1 12345 beef 1",
                         sram_we_n, sram_oe_n, sram_addr, sram_dq, bus.busy);
    end
    tick;
    checks++;
    if (sram_oe_n !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done: oe_n %b busy %b rdy %b expected 0 0 1",
                         sram_oe_n, bus.busy, bus.wr_ready);
    end
    bus.load_mode = 1'b0; bus.rd_addr = 20'h12345;
    tick; tick;
    checks++;
    if (bus.rd_data !== 16'hBEEF || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL wr_readback: data %h vld %b expected beef 1", bus.rd_data, bus.rd_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    int k = 0;
    int pulses = 0;
    a[0] = 20'hFFFFF; a[1] = 20'h00000; a[2] = 20'h80001;
    d[0] = 16'h1111;  d[1] = 16'h2222;  d[2] = 16'h3333;
    bus.load_mode = 1'b1;
    tick;
    for (int c = 0; c < 12; c++) begin
      logic exp_rdy;
      if (k < 3) begin
        bus.wr_valid = 1'b1; bus.wr_addr = a[k]; bus.wr_data = d[k];
      end else begin
        bus.wr_valid = 1'b0;
      end
      exp_rdy = (c % 4 == 0);
      checks++;
      if (bus.wr_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready c=%0d: got %b expected %b", c, bus.wr_ready, exp_rdy);
      end
      if (exp_rdy && k < 3) k++;
      tick;
      if (sram_we_n === 1'b0) pulses++;
      if ((c + 1) % 4 == 2) begin
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== a[(c + 1) / 4]) begin
          errors++; $display("FAIL b2b_pulse c=%0d: we_n %b addr %h expected 0 %h",
                             c, sram_we_n, sram_addr, a[(c + 1) / 4]);
        end
      end
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (pulses != 3) begin
      errors++; $display("FAIL b2b_pulse_count: got %0d expected 3", pulses);
    end
    bus.load_mode = 1'b0; bus.rd_addr = 20'hFFFFF;
    tick;
    bus.rd_addr = 20'h00000;
    tick;
    checks++;
    if (bus.rd_data !== 16'h1111 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_read_top: data %h vld %b expected 1111 1", bus.rd_data, bus.rd_valid);
    end
    tick;
    checks++;
    if (bus.rd_data !== 16'h2222 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_read_zero: data %h vld %b expected 2222 1", bus.rd_data, bus.rd_valid);
    end
  endtask

  task automatic test_mode_switch;
    bus.load_mode = 1'b1;
    tick;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00200; bus.wr_data = 16'h5A5A; bus.rd_addr = 20'h00030;
    tick;
    bus.load_mode = 1'b0; bus.wr_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL ms_setup: busy %b rdy %b expected 1 0", bus.busy, bus.wr_ready);
    end
    tick;
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 20'h00200 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL ms_pulse: we_n %b addr %h vld %b expected 0 00200 0",
                         sram_we_n, sram_addr, bus.rd_valid);
    end
    tick;
    checks++;
    if (sram_we_n !== 1'b1 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL ms_hold: we_n %b busy %b vld %b expected 1 1 0",
                         sram_we_n, bus.busy, bus.rd_valid);
    end
    tick;
    checks++;
    if ({sram_oe_n, bus.busy, bus.wr_ready, bus.rd_valid} !== 4'b0000 || sram_addr !== 20'h00030) begin
      errors++; $display("FAIL ms_reenter: oe/busy/rdy/vld %b addr %h expected 0000 00030",
                         {sram_oe_n, bus.busy, bus.wr_ready, bus.rd_valid}, sram_addr);
    end
    bus.rd_addr = 20'h00200;
    tick;
    checks++;
    if (bus.rd_data !== 16'hA595 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL ms_read_resume: data %h vld %b expected a595 1", bus.rd_data, bus.rd_valid);
    end
    tick;
    checks++;
    if (bus.rd_data !== 16'h5A5A || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL ms_write_landed: data %h vld %b expected 5a5a 1", bus.rd_data, bus.rd_valid);
    end
  endtask

  task automatic test_ignored_write;
    bus.load_mode = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00300; bus.wr_data = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] prev;
      logic [DW-1:0] exp_data;
      bus.rd_addr = 20'h00040 + 20'(i);
      tick;
      checks++;
      if ({bus.wr_ready, sram_we_n, sram_oe_n, bus.busy} !== 4'b0100) begin
        errors++; $display("FAIL ign_ctrl i=%0d: rdy/we/oe/busy %b expected 0100",
                           i, {bus.wr_ready, sram_we_n, sram_oe_n, bus.busy});
      end
      if (i >= 1) begin
        prev = 20'h00040 + 20'(i) - 20'd1;
        exp_data = prev[15:0] ^ 16'hA5A5;
        checks++;
        if (bus.rd_data !== exp_data || bus.rd_valid !== 1'b1) begin
          errors++; $display("FAIL ign_read i=%0d: data %h vld %b expected %h 1",
                             i, bus.rd_data, bus.rd_valid, exp_data);
        end
      end
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (written[20'h00300]) begin
      errors++; $display("FAIL ign_no_write: word 00300 written=1 expected 0");
    end
  endtask

  initial begin
    test_reset;
    test_read_latency;
    test_single_write;
    test_back_to_back;
    test_mode_switch;
    test_ignored_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
